// File: rtl/alu_issue_wb.sv
`timescale 1ns/1ps
// Issue -> EX -> WB pipeline around an external combinational ALU: small register
// file, EX->issue forwarding, and a WB output register with downstream backpressure.
module alu_issue_wb #(
  parameter int INPUTSIZE = 4,
  parameter int REGS      = 8,
  parameter int ADDRW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_aluc,
  input  logic                 in_cin,
  input  logic [ADDRW-1:0]     in_rs,
  input  logic [ADDRW-1:0]     in_rt,
  input  logic [ADDRW-1:0]     in_rd,
  output logic [INPUTSIZE-1:0] alu_a,
  output logic [INPUTSIZE-1:0] alu_b,
  output logic [3:0]           alu_aluc,
  output logic                 alu_cin,
  input  logic [INPUTSIZE-1:0] alu_r,
  input  logic                 alu_zf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRW-1:0]     out_rd,
  output logic [INPUTSIZE-1:0] out_r,
  output logic                 out_zf,
  output logic                 out_illegal,
  input  logic [ADDRW-1:0]     dbg_addr,
  output logic [INPUTSIZE-1:0] dbg_data
);

  logic [INPUTSIZE-1:0] rf_q [REGS];

  logic                 ex_valid_q, ex_valid_d;
  logic                 ex_legal_q, ex_legal_d;
  logic [ADDRW-1:0]     ex_rd_q, ex_rd_d;
  logic [INPUTSIZE-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]           alu_aluc_q, alu_aluc_d;
  logic                 alu_cin_q, alu_cin_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDRW-1:0]     out_rd_q, out_rd_d;
  logic [INPUTSIZE-1:0] out_r_q, out_r_d;
  logic                 out_zf_q, out_zf_d;
  logic                 out_illegal_q, out_illegal_d;

  logic wb_free, ex_adv, accept, wr_en, fwd_ok;
  logic [ADDRW-1:0]     src [2];
  logic [INPUTSIZE-1:0] opnd [2];

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1101, 4'b1110: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  assign wb_free  = !out_valid_q || out_ready;
  assign ex_adv   = ex_valid_q && wb_free;
  assign in_ready = !rst && (!ex_valid_q || ex_adv);
  assign accept   = in_valid && in_ready;
  // Illegal ops never reach the regfile, so they must not be forwarded either.
  assign fwd_ok   = ex_valid_q && ex_legal_q && (ex_rd_q != '0);
  assign wr_en    = ex_adv && ex_legal_q && (ex_rd_q != '0);

  assign src[0] = in_rs;
  assign src[1] = in_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign opnd[gi] = (src[gi] == '0)                     ? '0    :
                      (fwd_ok && (ex_rd_q == src[gi]))    ? alu_r :
                      (int'(src[gi]) >= REGS)             ? '0    : rf_q[src[gi]];
  end

  for (genvar gi = 0; gi < REGS; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (rst) begin
        rf_q[gi] <= '0;
      end else if (wr_en && (gi != 0) && (ex_rd_q == ADDRW'(gi))) begin
        rf_q[gi] <= alu_r;
      end
    end
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_legal_d    = ex_legal_q;
    ex_rd_d       = ex_rd_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_aluc_d    = alu_aluc_q;
    alu_cin_d     = alu_cin_q;
    out_valid_d   = out_valid_q;
    out_rd_d      = out_rd_q;
    out_r_d       = out_r_q;
    out_zf_d      = out_zf_q;
    out_illegal_d = out_illegal_q;
    // EX operands only change on accept, keeping the ALU output stable while stalled.
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_legal_d = is_legal(in_aluc);
      ex_rd_d    = in_rd;
      alu_a_d    = opnd[0];
      alu_b_d    = opnd[1];
      alu_aluc_d = in_aluc;
      alu_cin_d  = in_cin;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
    if (ex_adv) begin
      out_valid_d   = 1'b1;
      out_rd_d      = ex_rd_q;
      out_r_d       = alu_r;
      out_zf_d      = alu_zf;
      out_illegal_d = !ex_legal_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_legal_q    <= 1'b0;
      ex_rd_q       <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_aluc_q    <= '0;
      alu_cin_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_r_q       <= '0;
      out_zf_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_legal_q    <= ex_legal_d;
      ex_rd_q       <= ex_rd_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_aluc_q    <= alu_aluc_d;
      alu_cin_q     <= alu_cin_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_r_q       <= out_r_d;
      out_zf_q      <= out_zf_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  always_comb begin
    dbg_data = '0;
    if (int'(dbg_addr) < REGS) dbg_data = rf_q[dbg_addr];
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_aluc    = alu_aluc_q;
  assign alu_cin     = alu_cin_q;
  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_r       = out_r_q;
  assign out_zf      = out_zf_q;
  assign out_illegal = out_illegal_q;

endmodule
